// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the multi-issue pipeline.
// Purpose: selects EX operand sources (regfile / MEM/WB / EX/MEM, plus the source lane),
//          detects load-use hazards between the ID bundle and loads in ID/EX, holds the
//          pipeline for LOAD_LAT cycles per hazard, and provides the architectural N flag
//          with bypass from EX/MEM and MEM/WB.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   id_rs1, id_rs2                 ID-stage source registers (lane i at [i*AW +: AW])
//   id_ex_rs1, id_ex_rs2           EX-stage source registers
//   id_ex_use_rs2                  operand B reads a register (0 = immediate)
//   id_ex_rd, id_ex_we, id_ex_is_load  ID/EX destination, write enable, load marker
//   ex_mem_rd/we, mem_wb_rd/we     later-stage destinations and write enables
//   ex_mem_flag_we/n, mem_wb_flag_we/n  N-flag writes and values
//   flush                          branch redirect, aborts any stall
//   fwd_a_sel, fwd_b_sel           per lane: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   fwd_a_lane, fwd_b_lane         per lane: source lane of forwarded value
//   stall, bubble                  hold PC/IF-ID, zero ID/EX control
//   n_out                          current N flag seen by EX
module fwd_hazard_unit #(
    parameter int unsigned LANES    = 2,
    parameter int unsigned AW       = 3,
    parameter int unsigned LW       = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LANES*AW-1:0] id_rs1,
    input  logic [LANES*AW-1:0] id_rs2,
    input  logic [LANES*AW-1:0] id_ex_rs1,
    input  logic [LANES*AW-1:0] id_ex_rs2,
    input  logic [LANES-1:0]    id_ex_use_rs2,
    input  logic [LANES*AW-1:0] id_ex_rd,
    input  logic [LANES-1:0]    id_ex_we,
    input  logic [LANES-1:0]    id_ex_is_load,
    input  logic [LANES*AW-1:0] ex_mem_rd,
    input  logic [LANES*AW-1:0] mem_wb_rd,
    input  logic [LANES-1:0]    ex_mem_we,
    input  logic [LANES-1:0]    mem_wb_we,
    input  logic [LANES-1:0]    ex_mem_flag_we,
    input  logic [LANES-1:0]    mem_wb_flag_we,
    input  logic [LANES-1:0]    ex_mem_n,
    input  logic [LANES-1:0]    mem_wb_n,
    input  logic                flush,
    output logic [LANES*2-1:0]  fwd_a_sel,
    output logic [LANES*2-1:0]  fwd_b_sel,
    output logic [LANES*LW-1:0] fwd_a_lane,
    output logic [LANES*LW-1:0] fwd_b_lane,
    output logic                stall,
    output logic                bubble,
    output logic                n_out
);

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    localparam logic [1:0] CntInit = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       flag_q, flag_d;
    logic       haz;
    logic       stall_int;
    logic       n_byp;

    // Forwarding: scan MEM/WB first, then EX/MEM, each in ascending lane order, so later
    // matches overwrite earlier ones: EX/MEM beats MEM/WB and the highest lane wins.
    always_comb begin : fwd_blk
        logic [AW-1:0] src_a;
        logic [AW-1:0] src_b;
        fwd_a_sel  = '0;
        fwd_b_sel  = '0;
        fwd_a_lane = '0;
        fwd_b_lane = '0;
        for (int j = 0; j < LANES; j++) begin
            src_a = id_ex_rs1[j*AW +: AW];
            src_b = id_ex_rs2[j*AW +: AW];
            for (int k = 0; k < LANES; k++) begin
                if (mem_wb_we[k] && mem_wb_rd[k*AW +: AW] == src_a && src_a != '0) begin
                    fwd_a_sel[j*2 +: 2]   = 2'b01;
                    fwd_a_lane[j*LW +: LW] = LW'(k);
                end
                if (mem_wb_we[k] && mem_wb_rd[k*AW +: AW] == src_b && src_b != '0) begin
                    fwd_b_sel[j*2 +: 2]   = 2'b01;
                    fwd_b_lane[j*LW +: LW] = LW'(k);
                end
            end
            for (int k = 0; k < LANES; k++) begin
                if (ex_mem_we[k] && ex_mem_rd[k*AW +: AW] == src_a && src_a != '0) begin
                    fwd_a_sel[j*2 +: 2]   = 2'b10;
                    fwd_a_lane[j*LW +: LW] = LW'(k);
                end
                if (ex_mem_we[k] && ex_mem_rd[k*AW +: AW] == src_b && src_b != '0) begin
                    fwd_b_sel[j*2 +: 2]   = 2'b10;
                    fwd_b_lane[j*LW +: LW] = LW'(k);
                end
            end
            // Immediate operand B never takes a forwarded value.
            if (!id_ex_use_rs2[j]) begin
                fwd_b_sel[j*2 +: 2]   = 2'b00;
                fwd_b_lane[j*LW +: LW] = '0;
            end
        end
    end

    always_comb begin
        haz = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < LANES; k++) begin
                if (id_ex_we[k] && id_ex_is_load[k] && id_ex_rd[k*AW +: AW] != '0 &&
                    (id_rs1[i*AW +: AW] == id_ex_rd[k*AW +: AW] ||
                     id_rs2[i*AW +: AW] == id_ex_rd[k*AW +: AW])) begin
                    haz = 1'b1;
                end
            end
        end
    end

    // The first stall cycle is raised from IDLE; STALL covers the remaining LOAD_LAT-1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_int = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (haz) begin
                        stall_int = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StStall;
                            cnt_d   = CntInit;
                        end
                    end
                end
                StStall: begin
                    stall_int = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        flag_d = flag_q;
        for (int k = 0; k < LANES; k++) begin
            if (mem_wb_flag_we[k]) flag_d = mem_wb_n[k];
        end
        // flag_d already holds the youngest MEM/WB write or flag_q; EX/MEM overrides it.
        n_byp = flag_d;
        for (int k = 0; k < LANES; k++) begin
            if (ex_mem_flag_we[k]) n_byp = ex_mem_n[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    // Outputs are forced low while reset is held, even if bypass inputs are active.
    assign stall  = rst_n & stall_int;
    assign bubble = rst_n & stall_int;
    assign n_out  = rst_n & n_byp;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Two-lane instance, AW=3, LOAD_LAT=3.
    logic [5:0] a_id_rs1, a_id_rs2, a_id_ex_rs1, a_id_ex_rs2, a_id_ex_rd, a_ex_mem_rd, a_mem_wb_rd;
    logic [1:0] a_use_rs2, a_id_ex_we, a_id_ex_is_load, a_ex_mem_we, a_mem_wb_we;
    logic [1:0] a_ex_mem_flag_we, a_mem_wb_flag_we, a_ex_mem_n, a_mem_wb_n;
    logic       a_flush;
    logic [3:0] a_fwd_a_sel, a_fwd_b_sel;
    logic [1:0] a_fwd_a_lane, a_fwd_b_lane;
    logic       a_stall, a_bubble, a_n_out;

    // Four-lane instance, AW=5, LOAD_LAT=1.
    logic [19:0] b_id_rs1, b_id_rs2, b_id_ex_rs1, b_id_ex_rs2, b_id_ex_rd, b_ex_mem_rd, b_mem_wb_rd;
    logic [3:0]  b_use_rs2, b_id_ex_we, b_id_ex_is_load, b_ex_mem_we, b_mem_wb_we;
    logic [3:0]  b_ex_mem_flag_we, b_mem_wb_flag_we, b_ex_mem_n, b_mem_wb_n;
    logic        b_flush;
    logic [7:0]  b_fwd_a_sel, b_fwd_b_sel, b_fwd_a_lane, b_fwd_b_lane;
    logic        b_stall, b_bubble, b_n_out;

    fwd_hazard_unit #(.LANES(2), .AW(3), .LW(1), .LOAD_LAT(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(a_id_rs1), .id_rs2(a_id_rs2),
        .id_ex_rs1(a_id_ex_rs1), .id_ex_rs2(a_id_ex_rs2), .id_ex_use_rs2(a_use_rs2),
        .id_ex_rd(a_id_ex_rd), .id_ex_we(a_id_ex_we), .id_ex_is_load(a_id_ex_is_load),
        .ex_mem_rd(a_ex_mem_rd), .mem_wb_rd(a_mem_wb_rd),
        .ex_mem_we(a_ex_mem_we), .mem_wb_we(a_mem_wb_we),
        .ex_mem_flag_we(a_ex_mem_flag_we), .mem_wb_flag_we(a_mem_wb_flag_we),
        .ex_mem_n(a_ex_mem_n), .mem_wb_n(a_mem_wb_n), .flush(a_flush),
        .fwd_a_sel(a_fwd_a_sel), .fwd_b_sel(a_fwd_b_sel),
        .fwd_a_lane(a_fwd_a_lane), .fwd_b_lane(a_fwd_b_lane),
        .stall(a_stall), .bubble(a_bubble), .n_out(a_n_out)
    );

    fwd_hazard_unit #(.LANES(4), .AW(5), .LW(2), .LOAD_LAT(1)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(b_id_rs1), .id_rs2(b_id_rs2),
        .id_ex_rs1(b_id_ex_rs1), .id_ex_rs2(b_id_ex_rs2), .id_ex_use_rs2(b_use_rs2),
        .id_ex_rd(b_id_ex_rd), .id_ex_we(b_id_ex_we), .id_ex_is_load(b_id_ex_is_load),
        .ex_mem_rd(b_ex_mem_rd), .mem_wb_rd(b_mem_wb_rd),
        .ex_mem_we(b_ex_mem_we), .mem_wb_we(b_mem_wb_we),
        .ex_mem_flag_we(b_ex_mem_flag_we), .mem_wb_flag_we(b_mem_wb_flag_we),
        .ex_mem_n(b_ex_mem_n), .mem_wb_n(b_mem_wb_n), .flush(b_flush),
        .fwd_a_sel(b_fwd_a_sel), .fwd_b_sel(b_fwd_b_sel),
        .fwd_a_lane(b_fwd_a_lane), .fwd_b_lane(b_fwd_b_lane),
        .stall(b_stall), .bubble(b_bubble), .n_out(b_n_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_a();
        a_id_rs1 = '0; a_id_rs2 = '0; a_id_ex_rs1 = '0; a_id_ex_rs2 = '0; a_id_ex_rd = '0;
        a_ex_mem_rd = '0; a_mem_wb_rd = '0; a_use_rs2 = '0; a_id_ex_we = '0;
        a_id_ex_is_load = '0; a_ex_mem_we = '0; a_mem_wb_we = '0; a_ex_mem_flag_we = '0;
        a_mem_wb_flag_we = '0; a_ex_mem_n = '0; a_mem_wb_n = '0; a_flush = 1'b0;
    endtask

    task automatic clear_b();
        b_id_rs1 = '0; b_id_rs2 = '0; b_id_ex_rs1 = '0; b_id_ex_rs2 = '0; b_id_ex_rd = '0;
        b_ex_mem_rd = '0; b_mem_wb_rd = '0; b_use_rs2 = '0; b_id_ex_we = '0;
        b_id_ex_is_load = '0; b_ex_mem_we = '0; b_mem_wb_we = '0; b_ex_mem_flag_we = '0;
        b_mem_wb_flag_we = '0; b_ex_mem_n = '0; b_mem_wb_n = '0; b_flush = 1'b0;
    endtask

    // Load in ID/EX lane 0 writing r4, consumed by id_rs2 lane 0.
    task automatic set_haz_a(input logic on);
        a_id_ex_rd      = on ? 6'o04 : 6'o00;
        a_id_ex_we      = {1'b0, on};
        a_id_ex_is_load = {1'b0, on};
        a_id_rs2        = on ? 6'o04 : 6'o00;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        clear_a();
        clear_b();
        // Reset with a live hazard and EX/MEM flag bypass: outputs must stay low.
        set_haz_a(1'b1);
        a_ex_mem_flag_we = 2'b01; a_ex_mem_n = 2'b01;
        #1;
        check("rst_stall", 32'(a_stall), 32'd0);
        check("rst_bubble", 32'(a_bubble), 32'd0);
        check("rst_n_out", 32'(a_n_out), 32'd0);
        step(); step();
        clear_a();
        rst_n = 1'b1;

        // Forwarding: EX/MEM lane 1 beats MEM/WB lane 0 for rs1=3 in lane 0.
        step();
        a_id_ex_rs1 = {3'd0, 3'd3};
        a_ex_mem_rd = {3'd3, 3'd0}; a_ex_mem_we = 2'b10;
        a_mem_wb_rd = {3'd0, 3'd3}; a_mem_wb_we = 2'b01;
        #1;
        check("fwd_a_sel_exmem", 32'(a_fwd_a_sel), 32'b0010);
        check("fwd_a_lane_exmem", 32'(a_fwd_a_lane), 32'b01);
        a_ex_mem_we = 2'b00;
        #1;
        check("fwd_a_sel_memwb", 32'(a_fwd_a_sel), 32'b0001);
        check("fwd_a_lane_memwb", 32'(a_fwd_a_lane), 32'b00);
        a_mem_wb_rd = {3'd3, 3'd3}; a_mem_wb_we = 2'b11;
        #1;
        check("fwd_a_lane_memwb_young", 32'(a_fwd_a_lane), 32'b01);

        // Operand B: both EX/MEM lanes write r5, lane 1 wins.
        clear_a();
        a_ex_mem_rd = {3'd5, 3'd5}; a_ex_mem_we = 2'b11;
        a_id_ex_rs2 = {3'd5, 3'd0}; a_use_rs2 = 2'b10;
        #1;
        check("fwd_b_sel_young", 32'(a_fwd_b_sel), 32'b1000);
        check("fwd_b_lane_young", 32'(a_fwd_b_lane), 32'b10);
        a_use_rs2 = 2'b00;
        #1;
        check("fwd_b_sel_imm", 32'(a_fwd_b_sel), 32'b0000);
        check("fwd_b_lane_imm", 32'(a_fwd_b_lane), 32'b00);
        a_ex_mem_rd = '0; a_id_ex_rs2 = '0; a_use_rs2 = 2'b11;
        #1;
        check("fwd_b_sel_r0", 32'(a_fwd_b_sel), 32'b0000);

        // Load-use stall of exactly 3 cycles.
        clear_a();
        step();
        set_haz_a(1'b1);
        #1;
        check("stall_c1", 32'(a_stall), 32'd1);
        check("bubble_c1", 32'(a_bubble), 32'd1);
        step(); set_haz_a(1'b0); #1;
        check("stall_c2", 32'(a_stall), 32'd1);
        step(); #1;
        check("stall_c3", 32'(a_stall), 32'd1);
        check("bubble_c3", 32'(a_bubble), 32'd1);
        step(); #1;
        check("stall_c4", 32'(a_stall), 32'd0);

        // Persistent hazard: ignored in STALL, re-triggers from IDLE with no gap.
        step(); set_haz_a(1'b1); #1;
        check("b2b_c1", 32'(a_stall), 32'd1);
        step(); step(); step(); #1;
        check("b2b_c4", 32'(a_stall), 32'd1);
        step(); set_haz_a(1'b0); step(); #1;
        check("b2b_c6", 32'(a_stall), 32'd1);
        step(); #1;
        check("b2b_c7", 32'(a_stall), 32'd0);

        // Flush in the 2nd stall cycle aborts the stall.
        step(); set_haz_a(1'b1); #1;
        check("flush_c1", 32'(a_stall), 32'd1);
        step(); set_haz_a(1'b0); a_flush = 1'b1; #1;
        check("flush_c2_stall", 32'(a_stall), 32'd0);
        check("flush_c2_bubble", 32'(a_bubble), 32'd0);
        step(); a_flush = 1'b0; #1;
        check("flush_c3_idle", 32'(a_stall), 32'd0);
        // Flush in IDLE masks a hazard.
        set_haz_a(1'b1); a_flush = 1'b1; #1;
        check("flush_idle_haz", 32'(a_stall), 32'd0);
        a_flush = 1'b0;

        // Reset asserted mid-STALL drops stall immediately.
        step(); #1;
        check("rst_mid_c1", 32'(a_stall), 32'd1);
        step(); set_haz_a(1'b0); #1;
        check("rst_mid_c2", 32'(a_stall), 32'd1);
        rst_n = 1'b0; #1;
        check("rst_mid_stall", 32'(a_stall), 32'd0);
        step(); rst_n = 1'b1; #1;
        check("rst_mid_after", 32'(a_stall), 32'd0);
        step(); #1;
        check("rst_mid_after2", 32'(a_stall), 32'd0);

        // Flag: MEM/WB bypass then register; EX/MEM bypass does not touch flag_q.
        clear_a();
        a_mem_wb_flag_we = 2'b01; a_mem_wb_n = 2'b01; #1;
        check("n_memwb_byp", 32'(a_n_out), 32'd1);
        step(); a_mem_wb_flag_we = 2'b00; a_mem_wb_n = 2'b00; #1;
        check("n_flag_q_set", 32'(a_n_out), 32'd1);
        a_ex_mem_flag_we = 2'b10; a_ex_mem_n = 2'b01; #1;
        check("n_exmem_byp", 32'(a_n_out), 32'd0);
        step(); a_ex_mem_flag_we = 2'b00; a_ex_mem_n = 2'b00; #1;
        check("n_flag_q_hold", 32'(a_n_out), 32'd1);
        a_mem_wb_flag_we = 2'b11; a_mem_wb_n = 2'b01; #1;
        check("n_memwb_young", 32'(a_n_out), 32'd0);
        step(); a_mem_wb_flag_we = 2'b00; a_mem_wb_n = 2'b00; #1;
        check("n_flag_q_clear", 32'(a_n_out), 32'd0);

        // Four lanes, AW=5: r31 from EX/MEM lane 3 feeds every lane.
        b_ex_mem_rd = {5'd31, 15'd0}; b_ex_mem_we = 4'b1000;
        b_mem_wb_rd = {4{5'd31}}; b_mem_wb_we = 4'b1111;
        b_id_ex_rs1 = {4{5'd31}}; b_id_ex_rs2 = {4{5'd31}}; b_use_rs2 = 4'b1111;
        #1;
        check("l4_fwd_a_sel", 32'(b_fwd_a_sel), 32'hAA);
        check("l4_fwd_a_lane", 32'(b_fwd_a_lane), 32'hFF);
        check("l4_fwd_b_sel", 32'(b_fwd_b_sel), 32'hAA);
        check("l4_fwd_b_lane", 32'(b_fwd_b_lane), 32'hFF);
        // Load in lane 2 writing r17 read by id_rs1 lane 3; LOAD_LAT=1.
        clear_b();
        step();
        b_id_ex_rd = {5'd0, 5'd17, 10'd0}; b_id_ex_we = 4'b0100; b_id_ex_is_load = 4'b0100;
        b_id_rs1 = {5'd17, 15'd0};
        #1;
        check("l4_stall_c1", 32'(b_stall), 32'd1);
        step(); #1;
        check("l4_stall_retrig", 32'(b_stall), 32'd1);
        step(); b_id_ex_is_load = 4'b0000; #1;
        check("l4_stall_done", 32'(b_stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
